// File: rtl/reg_serial_reader_pkg.sv
// Package: reg_serial_reader_pkg
// Shared types for the register serial reader.
//   rsr_state_t : transfer FSM state encoding (IDLE, SHIFT, PARITY, DONE).
package reg_serial_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } rsr_state_t;

endpackage

// File: rtl/reg_shift_out.sv
// Module: reg_shift_out
// Loadable shift register that presents one bit at a time, with zero fill.
// Parameters:
//   WIDTH     : register width in bits (>= 2)
//   MSB_FIRST : 1 shifts toward the MSB end and presents sr[WIDTH-1];
//               0 shifts toward the LSB end and presents sr[0]
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset, clears the register
//   load      in   capture load_data (takes priority over shift_en)
//   shift_en  in   shift one place
//   load_data in   parallel value to capture
//   bit_out   out  current output bit
module reg_shift_out #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/reg_serial_reader.sv
// Module: reg_serial_reader
// Captures a WIDTH-bit register value on rd_req and streams it out one bit per
// accepted valid/ready beat, then pulses done for one cycle.
// Optional feature: define REG_SERIAL_READER_PARITY_EN to append one even-parity
// beat after the data bits.
// Parameters:
//   WIDTH     : data width in bits (>= 2)
//   MSB_FIRST : 1 sends MSB first, 0 sends LSB first
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   rd_req    in   start a read (sampled only in IDLE)
//   rd_data   in   parallel value, captured on the accepting edge
//   busy      out  transfer in progress
//   ser_out   out  current serial bit
//   ser_valid out  ser_out holds a bit for the consumer
//   ser_ready in   consumer accepts ser_out at posedge when ser_valid=1
//   done      out  one-cycle pulse after the last beat is accepted
module reg_serial_reader
  import reg_serial_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

  rsr_state_t    state_q;
  rsr_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          load;
  logic          shift_en;
  logic          sr_bit;

  reg_shift_out #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .load_data(rd_data),
    .bit_out  (sr_bit)
  );

`ifdef REG_SERIAL_READER_PARITY_EN
  // Even parity of the captured word, sent as the extra beat.
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^rd_data;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    busy      = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = sr_bit;
        if (ser_ready) begin
          shift_en = 1'b1;
          // Counter saturates at the last index instead of wrapping.
          if (cnt_q == CntMax) begin
`ifdef REG_SERIAL_READER_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
`ifdef REG_SERIAL_READER_PARITY_EN
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = parity_q;
        if (ser_ready) begin
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_serial_reader.sv
// Testbench: tb_reg_serial_reader
// Directed checks of reg_serial_reader with WIDTH=8. Instance u_msb uses MSB_FIRST=1,
// instance u_lsb uses MSB_FIRST=0. Honours REG_SERIAL_READER_PARITY_EN.
module tb_reg_serial_reader;

`ifdef REG_SERIAL_READER_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       ser_ready = 1'b0;
  logic       busy, ser_out, ser_valid, done;

  logic       rd_req2 = 1'b0;
  logic [7:0] rd_data2 = 8'h00;
  logic       ser_ready2 = 1'b0;
  logic       busy2, ser_out2, ser_valid2, done2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  reg_serial_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .done     (done)
  );

  reg_serial_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req2),
    .rd_data  (rd_data2),
    .busy     (busy2),
    .ser_out  (ser_out2),
    .ser_valid(ser_valid2),
    .ser_ready(ser_ready2),
    .done     (done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_req = 1'b0;
    rd_req2 = 1'b0;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({busy, ser_valid, done, ser_out} !== 4'b0000) begin
      $display("FAIL reset_msb: busy/valid/done/out=%b required 0000",
               {busy, ser_valid, done, ser_out});
    end else pass_cnt++;
    total_cnt++;
    if ({busy2, ser_valid2, done2, ser_out2} !== 4'b0000) begin
      $display("FAIL reset_lsb: busy/valid/done/out=%b required 0000",
               {busy2, ser_valid2, done2, ser_out2});
    end else pass_cnt++;
  endtask

  // A5 MSB first: 1,0,1,0,0,1,0,1 then parity 0 (four ones).
  task automatic test_stream_a5();
    logic [7:0] exp_bits;
    exp_bits = 8'b1010_0101;
    ser_ready = 1'b1;
    rd_data = 8'hA5;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (ser_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || ser_out !== exp_bits[7-i]) begin
        $display("FAIL a5_bit%0d: valid=%b busy=%b done=%b out=%b required 1 1 0 %b",
                 i, ser_valid, busy, done, ser_out, exp_bits[7-i]);
      end else pass_cnt++;
      tick();
    end
    if (ParityEn) begin
      total_cnt++;
      if (ser_valid !== 1'b1 || ser_out !== 1'b0) begin
        $display("FAIL a5_parity: valid=%b out=%b required 1 0", ser_valid, ser_out);
      end else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || ser_valid !== 1'b0) begin
      $display("FAIL a5_done: done=%b busy=%b valid=%b required 1 0 0", done, busy, ser_valid);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL a5_done_once: done=%b busy=%b required 0 0", done, busy);
    end else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_bits;
    int         beats;
    exp_bits = 8'b1010_0101;
    beats = 0;
    ser_ready = 1'b1;
    rd_data = 8'hA5;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    rd_data = 8'h00;  // capture already happened; must not matter
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          total_cnt++;
          if (ser_valid !== 1'b1 || ser_out !== 1'b1) begin
            $display("FAIL bp_hold%0d: valid=%b out=%b required 1 1", s, ser_valid, ser_out);
          end else pass_cnt++;
        end
        ser_ready = 1'b1;
      end
      total_cnt++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[7-i]) begin
        $display("FAIL bp_bit%0d: valid=%b out=%b required 1 %b",
                 i, ser_valid, ser_out, exp_bits[7-i]);
      end else pass_cnt++;
      beats++;
      tick();
    end
    if (ParityEn) tick();
    total_cnt++;
    if (done !== 1'b1 || beats != 8) begin
      $display("FAIL bp_done: done=%b beats=%0d required 1 8", done, beats);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_ignore_req();
    logic [7:0] exp_bits;
    int         dones;
    exp_bits = 8'b1010_0101;
    dones = 0;
    ser_ready = 1'b1;
    rd_data = 8'hA5;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 1 && i <= 4) begin
        rd_req = 1'b1;
        rd_data = 8'hFF;
      end else begin
        rd_req = 1'b0;
      end
      total_cnt++;
      if (ser_out !== exp_bits[7-i]) begin
        $display("FAIL ign_bit%0d: out=%b required %b", i, ser_out, exp_bits[7-i]);
      end else pass_cnt++;
      tick();
    end
    rd_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    total_cnt++;
    if (dones != 1 || busy !== 1'b0) begin
      $display("FAIL ign_done_count: dones=%0d busy=%b required 1 0", dones, busy);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_bits;
    ser_ready = 1'b1;
    rd_data = 8'hA5;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({busy, ser_valid, done} !== 3'b000) begin
      $display("FAIL rstmid_idle: busy/valid/done=%b required 000", {busy, ser_valid, done});
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, ser_valid, done} !== 3'b000) begin
      $display("FAIL rstmid_nodone: busy/valid/done=%b required 000", {busy, ser_valid, done});
    end else pass_cnt++;
    // 3C MSB first: 0,0,1,1,1,1,0,0
    exp_bits = 8'b0011_1100;
    rd_data = 8'h3C;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (ser_valid !== 1'b1 || ser_out !== exp_bits[7-i]) begin
        $display("FAIL rstmid_3c_bit%0d: valid=%b out=%b required 1 %b",
                 i, ser_valid, ser_out, exp_bits[7-i]);
      end else pass_cnt++;
      tick();
    end
    if (ParityEn) begin
      total_cnt++;
      if (ser_out !== 1'b0) begin
        $display("FAIL rstmid_3c_parity: out=%b required 0", ser_out);
      end else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done !== 1'b1) begin
      $display("FAIL rstmid_3c_done: done=%b required 1", done);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    // 01 LSB first: 1,0,0,0,0,0,0,0
    exp_bits = 8'b0000_0001;
    ser_ready2 = 1'b1;
    rd_data2 = 8'h01;
    rd_req2 = 1'b1;
    tick();
    rd_req2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (ser_valid2 !== 1'b1 || ser_out2 !== exp_bits[i]) begin
        $display("FAIL lsb01_bit%0d: valid=%b out=%b required 1 %b",
                 i, ser_valid2, ser_out2, exp_bits[i]);
      end else pass_cnt++;
      tick();
    end
    if (ParityEn) tick();
    total_cnt++;
    if (done2 !== 1'b1) begin
      $display("FAIL lsb01_done: done=%b required 1", done2);
    end else pass_cnt++;
    tick();
    // 07 LSB first: 1,1,1,0,0,0,0,0 then parity 1 (three ones).
    exp_bits = 8'b0000_0111;
    rd_data2 = 8'h07;
    rd_req2 = 1'b1;
    tick();
    rd_req2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (ser_out2 !== exp_bits[i]) begin
        $display("FAIL lsb07_bit%0d: out=%b required %b", i, ser_out2, exp_bits[i]);
      end else pass_cnt++;
      tick();
    end
    if (ParityEn) begin
      total_cnt++;
      if (ser_valid2 !== 1'b1 || ser_out2 !== 1'b1) begin
        $display("FAIL lsb07_parity: valid=%b out=%b required 1 1", ser_valid2, ser_out2);
      end else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (done2 !== 1'b1 || busy2 !== 1'b0) begin
      $display("FAIL lsb07_done: done=%b busy=%b required 1 0", done2, busy2);
    end else pass_cnt++;
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_stream_a5();
    test_backpressure();
    test_ignore_req();
    test_reset_mid();
    test_lsb_first();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
